// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-entry FIFO: geometry and state codes.
// Latency: n/a (constants and types only).
// Backpressure: n/a; fifo_ns, fifo_ctrl and the bench all use one definition.
package fifo_pkg;

    localparam int DEPTH = 8;
    localparam int AW    = 3;   // log2(DEPTH)
    localparam int CW    = 4;   // log2(DEPTH)+1, holds 0..DEPTH

    // State codes exchanged between fifo_ns and fifo_ctrl.
    // Codes 011 and 100 are unused and decode as ST_NO_OP.
    typedef enum logic [2:0] {
        ST_INIT     = 3'b000,
        ST_WRITE    = 3'b001,
        ST_READ     = 3'b010,
        ST_WR_ERROR = 3'b101,
        ST_RD_ERROR = 3'b110,
        ST_NO_OP    = 3'b111
    } state_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping AW-bit pointer register (FIFO head or tail).
// Latency: 1 cycle; inc/clr take effect at the next rising edge, clr wins.
// Backpressure: none; the caller decides when to advance.
// Ports: clk, reset_n (async active-low), inc (advance by 1 mod 2^AW),
//        clr (synchronous return to 0), ptr (current pointer value).
module fifo_ptr #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          inc,
    input  logic          clr,
    output logic [AW-1:0] ptr
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            // Natural AW-bit overflow gives the modulo-DEPTH wrap.
            ptr <= ptr + AW'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Sequential control stage of the FIFO: state register, head/tail pointers,
// occupancy count, register-file strobes and one-cycle handshake flags.
// Latency: strobes/addresses same cycle; count, state, flags 1 cycle later.
// Backpressure: WRITE while full becomes WR_ERROR, READ while empty becomes
//               RD_ERROR; neither touches pointers or count.
// Ports: clk, reset_n (async active-low), next_state (from fifo_ns),
//        state/data_count (fed back to fifo_ns), wr_addr/rd_addr/we/re
//        (register file), full/empty, wr_ack/wr_err/rd_ack/rd_err.
module fifo_ctrl #(
    parameter int DEPTH = fifo_pkg::DEPTH,
    parameter int AW    = fifo_pkg::AW,
    parameter int CW    = fifo_pkg::CW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [2:0]    next_state,
    output logic [2:0]    state,
    output logic [CW-1:0] data_count,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic          we,
    output logic          re,
    output logic          full,
    output logic          empty,
    output logic          wr_ack,
    output logic          wr_err,
    output logic          rd_ack,
    output logic          rd_err
);

    import fifo_pkg::*;

    state_t state_q;
    state_t eff_state;

    assign full  = (data_count == CW'(DEPTH));
    assign empty = (data_count == '0);
    assign state = state_q;

    // Effective state: guards applied, unused codes folded to NO_OP.
    always_comb begin
        eff_state = ST_NO_OP;
        case (next_state)
            ST_INIT:     eff_state = ST_INIT;
            ST_WRITE:    eff_state = full  ? ST_WR_ERROR : ST_WRITE;
            ST_READ:     eff_state = empty ? ST_RD_ERROR : ST_READ;
            ST_WR_ERROR: eff_state = ST_WR_ERROR;
            ST_RD_ERROR: eff_state = ST_RD_ERROR;
            default:     eff_state = ST_NO_OP;
        endcase
    end

    // Strobes are held low while reset is asserted so the register file
    // never captures during reset, whatever fifo_ns is presenting.
    assign we = reset_n && (eff_state == ST_WRITE);
    assign re = reset_n && (eff_state == ST_READ);

    fifo_ptr #(.AW(AW)) u_tail (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (eff_state == ST_WRITE),
        .clr     (eff_state == ST_INIT),
        .ptr     (wr_addr)
    );

    fifo_ptr #(.AW(AW)) u_head (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (eff_state == ST_READ),
        .clr     (eff_state == ST_INIT),
        .ptr     (rd_addr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_INIT;
            data_count <= '0;
            wr_ack     <= 1'b0;
            wr_err     <= 1'b0;
            rd_ack     <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            state_q <= eff_state;
            // The guards keep the count inside 0..DEPTH without saturation.
            case (eff_state)
                ST_INIT:  data_count <= '0;
                ST_WRITE: data_count <= data_count + CW'(1);
                ST_READ:  data_count <= data_count - CW'(1);
                default:  data_count <= data_count;
            endcase
            // Flags follow the effective state, so each lasts one cycle
            // and at most one is ever set.
            wr_ack <= (eff_state == ST_WRITE);
            wr_err <= (eff_state == ST_WR_ERROR);
            rd_ack <= (eff_state == ST_READ);
            rd_err <= (eff_state == ST_RD_ERROR);
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl: reset, fill, overflow, drain, underflow,
// wrap-around, illegal code and soft clear, with hand-computed expectations.
module tb_fifo_ctrl;

    import fifo_pkg::*;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    next_state;
    logic [2:0]    state;
    logic [CW-1:0] data_count;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          we;
    logic          re;
    logic          full;
    logic          empty;
    logic          wr_ack;
    logic          wr_err;
    logic          rd_ack;
    logic          rd_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Flag vector order: {wr_ack, wr_err, rd_ack, rd_err}
    localparam int F_NONE = 0;
    localparam int F_WACK = 8;
    localparam int F_WERR = 4;
    localparam int F_RACK = 2;
    localparam int F_RERR = 1;

    always #5 clk = ~clk;

    fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .next_state (next_state),
        .state      (state),
        .data_count (data_count),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr),
        .we         (we),
        .re         (re),
        .full       (full),
        .empty      (empty),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int flags();
        return int'({wr_ack, wr_err, rd_ack, rd_err});
    endfunction

    // One decision cycle: drive next_state at the falling edge, check the
    // same-cycle strobes/addresses, then check registered results after
    // the rising edge.
    task automatic step(input string tag, input logic [2:0] ns,
                        input int e_we, input int e_re,
                        input int e_wa, input int e_ra,
                        input int e_state, input int e_cnt, input int e_flags);
        @(negedge clk);
        next_state = ns;
        #1;
        chk({tag, ".we"}, int'(we), e_we);
        chk({tag, ".re"}, int'(re), e_re);
        chk({tag, ".wr_addr"}, int'(wr_addr), e_wa);
        chk({tag, ".rd_addr"}, int'(rd_addr), e_ra);
        @(posedge clk);
        #1;
        chk({tag, ".state"}, int'(state), e_state);
        chk({tag, ".count"}, int'(data_count), e_cnt);
        chk({tag, ".flags"}, flags(), e_flags);
        chk({tag, ".full"}, int'(full), (e_cnt == 8) ? 1 : 0);
        chk({tag, ".empty"}, int'(empty), (e_cnt == 0) ? 1 : 0);
    endtask

    initial begin
        reset_n    = 1'b0;
        next_state = ST_NO_OP;
        #1;
        chk("rst0.state", int'(state), 0);
        chk("rst0.count", int'(data_count), 0);
        chk("rst0.empty", int'(empty), 1);
        chk("rst0.full", int'(full), 0);
        chk("rst0.flags", flags(), F_NONE);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Load 5 entries, then reset asynchronously in mid-cycle.
        for (int i = 0; i < 5; i++)
            step("pre", ST_WRITE, 1, 0, i, 0, 1, i + 1, F_WACK);
        #2;
        next_state = ST_WRITE;
        reset_n = 1'b0;
        #1;
        chk("arst.count", int'(data_count), 0);
        chk("arst.empty", int'(empty), 1);
        chk("arst.full", int'(full), 0);
        chk("arst.state", int'(state), 0);
        chk("arst.flags", flags(), F_NONE);
        chk("arst.we", int'(we), 0);
        chk("arst.re", int'(re), 0);
        chk("arst.wr_addr", int'(wr_addr), 0);
        next_state = ST_NO_OP;
        @(negedge clk);
        reset_n = 1'b1;

        // Fill from empty.
        for (int i = 0; i < 8; i++)
            step("fill", ST_WRITE, 1, 0, i, 0, 1, i + 1, F_WACK);
        chk("fill.tail", int'(wr_addr), 0);

        // Overflow guard, then the error flag must drop after one cycle.
        step("ovf", ST_WRITE, 0, 0, 0, 0, 5, 8, F_WERR);
        step("ovf_nop", ST_NO_OP, 0, 0, 0, 0, 7, 8, F_NONE);

        // Drain, then underflow.
        for (int i = 0; i < 8; i++)
            step("drain", ST_READ, 0, 1, 0, i, 2, 7 - i, F_RACK);
        step("udf", ST_READ, 0, 0, 0, 0, 6, 0, F_RERR);

        // Wrap-around: write 3, read 3, write 7 (tail 3 -> 7 -> 0 -> 2).
        for (int i = 0; i < 3; i++)
            step("wr3", ST_WRITE, 1, 0, i, 0, 1, i + 1, F_WACK);
        for (int i = 0; i < 3; i++)
            step("rd3", ST_READ, 0, 1, 3, i, 2, 2 - i, F_RACK);
        for (int i = 0; i < 7; i++)
            step("wr7", ST_WRITE, 1, 0, (3 + i) % 8, 3, 1, i + 1, F_WACK);
        chk("wrap.tail", int'(wr_addr), 2);
        chk("wrap.head", int'(rd_addr), 3);

        // Unused code 100 behaves as NO_OP.
        step("ill100", 3'b100, 0, 0, 2, 3, 7, 7, F_NONE);
        chk("ill100.tail", int'(wr_addr), 2);
        chk("ill100.head", int'(rd_addr), 3);

        // Bring count to 4, then soft clear with INIT.
        for (int i = 0; i < 3; i++)
            step("rd_to4", ST_READ, 0, 1, 2, 3 + i, 2, 6 - i, F_RACK);
        step("clr", ST_INIT, 0, 0, 2, 6, 0, 0, F_NONE);
        chk("clr.tail", int'(wr_addr), 0);
        chk("clr.head", int'(rd_addr), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
